ceespu_video_timing: RTL and testbench
======================================

// Module: ceespu_video_timing
// PURPOSE
//   Pixel-clock raster generator directly upstream of ceespu_gpu. Produces the x/y pixel
//   coordinates that ceespu_gpu consumes, plus hsync/vsync/data-enable for the HDMI controller.
//   Syncs and data-enable are delayed by PIPE_DELAY cycles so they line up with the RGB that
//   ceespu_gpu returns. Also provides frame-start, vblank and frame-count status.
// PARAMETERS
//   H_ACTIVE    640  visible pixels per line
//   H_FP        16   horizontal front porch, pixels
//   H_SYNC      96   hsync width, pixels
//   H_BP        48   horizontal back porch, pixels
//   V_ACTIVE    480  visible lines per frame
//   V_FP        10   vertical front porch, lines
//   V_SYNC      2    vsync width, lines
//   V_BP        33   vertical back porch, lines
//   HSYNC_POL   0    sync active level (0 = active-low)
//   VSYNC_POL   0    same for vsync
//   PIPE_DELAY  2    cycles from O_x/O_y to the matching RGB at the ceespu_gpu output (1..4)
// PORTS
//   I_pix_clk      in   1   pixel clock; the only clock
//   I_reset        in   1   synchronous, active-high reset
//   O_x            out  10  pixel column to ceespu_gpu; 0 during blanking
//   O_y            out  9   pixel row to ceespu_gpu; 0 during blanking
//   O_hsync        out  1   delayed hsync, polarity per HSYNC_POL
//   O_vsync        out  1   delayed vsync, polarity per VSYNC_POL
//   O_de           out  1   delayed data-enable, aligned with the ceespu_gpu RGB output
//   O_frame_start  out  1   1-cycle pulse when the raster is at (0,0); undelayed
//   O_vblank       out  1   level, 1 while v_cnt >= V_ACTIVE; undelayed
//   O_frame_count  out  16  frames completed since reset; wraps at 16'hFFFF
// BEHAVIOUR
//   - H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
//   - h_cnt, v_cnt: 10-bit counters. h_cnt counts 0..H_TOTAL-1 and wraps to 0.
//   - v_cnt increments only on the h_cnt wrap. It wraps 524 -> 0 on the same edge that h wraps.
//   - Raw active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//   - O_x and O_y are combinational from the counters:
//       - O_x = h_cnt when h_cnt < H_ACTIVE, else 0.
//       - O_y = v_cnt[8:0] when v_cnt < V_ACTIVE, else 0.
//   - Raw hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
//   - Raw vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
//     It spans whole lines and changes at h_cnt = 0.
//   - Raw hsync, vsync and active pass through a PIPE_DELAY-stage shift register.
//     The sync outputs are driven at the configured polarity (sync-level = POL when asserted).
//   - Invariant: O_de at cycle t+PIPE_DELAY equals raw active at cycle t.
//   - O_frame_start = (h_cnt == 0) && (v_cnt == 0); it is high in the first cycle after reset.
//   - O_frame_count increments on the edge where both counters wrap to 0.
//   - Reset values: h_cnt = 0, v_cnt = 0, O_frame_count = 0.
//     All delay stages are cleared to inactive: de = 0, syncs at ~POL.
//   - Reset is honoured mid-frame. On the first edge with I_reset high, all state returns to
//     the values above, with no partial sync pulse afterwards.
//   - Reset has priority over counting. With reset held, state stays at the reset values.
// STRUCTURE
//   - Package ceespu_video_pkg holds:
//       - the 640x480@60 timing constants used as parameter defaults;
//       - derived H_TOTAL/V_TOTAL and the sync-start/sync-end localparams;
//       - the counter widths;
//       - a struct {hsync, vsync, de} for the delay line.
//   - One sub-module: ceespu_delay_line, a parameterised WIDTH x DEPTH shift register with
//     synchronous reset to a RESET_VALUE vector. It is instantiated once for {hsync, vsync, de}.
// TESTING
//   1. Hold I_reset 5 cycles, release.
//        -> O_de = 0, O_hsync = O_vsync = 1, O_x = O_y = 0.
//        -> O_frame_start = 1 in the first post-reset cycle, O_frame_count = 0.
//   2. Run one line.
//        -> O_hsync low for exactly 96 cycles, starting 656+PIPE_DELAY cycles after h_cnt = 0.
//        -> O_x counts 0..639, then holds 0 for 160 cycles.
//   3. Run one frame (420000 cycles).
//        -> O_vsync low for exactly 1600 cycles starting at line 490.
//        -> O_vblank high for 45 lines.
//        -> O_frame_count = 1, and O_frame_start pulses exactly twice (start and wrap).
//   4. Check alignment at (x,y) = (639,479).
//        -> O_de high at that coordinate, shifted PIPE_DELAY cycles.
//        -> O_de falls exactly PIPE_DELAY cycles after O_x leaves 639.
//        -> Repeat with PIPE_DELAY = 1 and 4.
//   5. Assert I_reset for 1 cycle at (h,v) = (700,491), mid hsync and vsync.
//        -> Next cycle: counters = 0.
//        -> Syncs deasserted and de = 0 through all delay stages; no residual pulse.
//   6. Force O_frame_count to 16'hFFFF and complete a frame.
//        -> O_frame_count wraps to 0, and O_frame_start pulses in the same cycle.

Source files
------------

// File: rtl/ceespu_video_pkg.sv
// Shared constants and types for the ceespu raster generator.
//   - 640x480@60 timing defaults and their derived totals / sync windows
//   - counter and output widths
//   - sync_bus_t: the {hsync, vsync, de} bundle carried through the alignment delay line
package ceespu_video_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned FRAME_W = 16;

  function automatic int unsigned total_len(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // First counter value with sync asserted.
  function automatic int unsigned sync_first(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  // Last counter value with sync asserted (inclusive).
  function automatic int unsigned sync_last(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync);
    return active + fp + sync - 1;
  endfunction

  localparam int unsigned H_TOTAL_DEF  = total_len(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF  = total_len(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int unsigned HS_START_DEF = sync_first(H_ACTIVE_DEF, H_FP_DEF);
  localparam int unsigned HS_END_DEF   = sync_last(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF);
  localparam int unsigned VS_START_DEF = sync_first(V_ACTIVE_DEF, V_FP_DEF);
  localparam int unsigned VS_END_DEF   = sync_last(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF);

  // Sync fields hold the pin level (polarity already applied), not the asserted flag.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bus_t;

endpackage

// File: rtl/ceespu_delay_line.sv
// WIDTH x DEPTH shift register with synchronous reset of every stage to RESET_VALUE.
// Ports:
//   clk  in            clock
//   rst  in            synchronous active-high reset
//   d    in  [WIDTH]   data entering stage 0
//   q    out [WIDTH]   data leaving the last stage (DEPTH cycles after d)
module ceespu_delay_line #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/ceespu_video_timing.sv
// Pixel-clock raster generator feeding ceespu_gpu and the HDMI controller.
// Ports:
//   I_pix_clk      in       pixel clock
//   I_reset        in       synchronous active-high reset
//   O_x            out [10] pixel column, 0 during blanking (undelayed)
//   O_y            out [9]  pixel row, 0 during blanking (undelayed)
//   O_hsync        out      hsync at HSYNC_POL, delayed PIPE_DELAY cycles
//   O_vsync        out      vsync at VSYNC_POL, delayed PIPE_DELAY cycles
//   O_de           out      data-enable, delayed PIPE_DELAY cycles to match the GPU RGB
//   O_frame_start  out      high while the raster sits at (0,0)
//   O_vblank       out      high while the line counter is past the active region
//   O_frame_count  out [16] frames completed since reset, wrapping
module ceespu_video_timing
  import ceespu_video_pkg::*;
#(
  parameter int unsigned        H_ACTIVE         = H_ACTIVE_DEF,
  parameter int unsigned        H_FP             = H_FP_DEF,
  parameter int unsigned        H_SYNC           = H_SYNC_DEF,
  parameter int unsigned        H_BP             = H_BP_DEF,
  parameter int unsigned        V_ACTIVE         = V_ACTIVE_DEF,
  parameter int unsigned        V_FP             = V_FP_DEF,
  parameter int unsigned        V_SYNC           = V_SYNC_DEF,
  parameter int unsigned        V_BP             = V_BP_DEF,
  parameter bit                 HSYNC_POL        = 1'b0,
  parameter bit                 VSYNC_POL        = 1'b0,
  parameter int unsigned        PIPE_DELAY       = 2,
  // Value the frame counter takes on reset; lets wrap behaviour be reached without
  // running 65536 frames.
  parameter logic [FRAME_W-1:0] FRAME_COUNT_INIT = '0
) (
  input  logic               I_pix_clk,
  input  logic               I_reset,
  output logic [X_W-1:0]     O_x,
  output logic [Y_W-1:0]     O_y,
  output logic               O_hsync,
  output logic               O_vsync,
  output logic               O_de,
  output logic               O_frame_start,
  output logic               O_vblank,
  output logic [FRAME_W-1:0] O_frame_count
);

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(total_len(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(total_len(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

  localparam sync_bus_t IDLE_BUS = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, de: 1'b0};

  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               h_wrap, v_wrap;
  logic               h_active, v_active;
  logic               hsync_raw, vsync_raw;
  sync_bus_t          bus_raw, bus_dly;

  always_comb begin
    h_wrap        = (h_cnt_q == H_LAST);
    v_wrap        = (v_cnt_q == V_LAST);
    h_cnt_d       = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d       = v_cnt_q;
    frame_count_d = frame_count_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
      if (v_wrap) begin
        frame_count_d = frame_count_q + FRAME_W'(1);
      end
    end
  end

  // Reset outranks counting, so a held reset parks the raster at (0,0).
  always_ff @(posedge I_pix_clk) begin
    if (I_reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_count_q <= FRAME_COUNT_INIT;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    h_active  = (h_cnt_q < H_ACT_C);
    v_active  = (v_cnt_q < V_ACT_C);
    hsync_raw = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    // Depends on v_cnt only, so vsync edges fall on h_cnt = 0.
    vsync_raw = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);

    bus_raw.hsync = hsync_raw ? HSYNC_POL : ~HSYNC_POL;
    bus_raw.vsync = vsync_raw ? VSYNC_POL : ~VSYNC_POL;
    bus_raw.de    = h_active && v_active;

    O_x           = h_active ? h_cnt_q : '0;
    O_y           = v_active ? v_cnt_q[Y_W-1:0] : '0;
    O_frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    O_vblank      = ~v_active;
    O_frame_count = frame_count_q;
    O_hsync       = bus_dly.hsync;
    O_vsync       = bus_dly.vsync;
    O_de          = bus_dly.de;
  end

  // Reset clears every stage to idle levels so an interrupted sync pulse cannot drain out.
  ceespu_delay_line #(
    .WIDTH      ($bits(sync_bus_t)),
    .DEPTH      (PIPE_DELAY),
    .RESET_VALUE(IDLE_BUS)
  ) u_sync_dly (
    .clk(I_pix_clk),
    .rst(I_reset),
    .d  (bus_raw),
    .q  (bus_dly)
  );

endmodule

// File: tb/tb_ceespu_video_timing.sv
// Bench for ceespu_video_timing: one instance at the 640x480 defaults plus four reduced-raster
// instances (PIPE_DELAY 1/2/4/3, the last with inverted sync polarity and the frame counter
// preloaded to 16'hFFFF). Every cycle all instances are compared against an arithmetic model.
`timescale 1ns/1ps
module tb_ceespu_video_timing;
  import ceespu_video_pkg::*;

  localparam int unsigned NS  = 4;
  localparam int unsigned SHA = 20, SHF = 3, SHS = 5, SHB = 4;
  localparam int unsigned SVA = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int unsigned SHT = 32, SFR = 608;   // 20+3+5+4 ; 32 * (12+2+2+3)
  localparam int unsigned T_LAST_PIX = 11 * 32 + 19;   // raster time of (19,11)
  localparam int unsigned T_MID_SYNC = 15 * 32 + 27;   // (h,v) = (27,15): inside both syncs

  function automatic int unsigned s_pd(input int unsigned i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 3;
    endcase
  endfunction
  function automatic bit s_pol(input int unsigned i);
    return (i == 3);
  endfunction
  function automatic logic [15:0] s_init(input int unsigned i);
    return (i == 3) ? 16'hFFFF : 16'h0000;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  d_x;
  logic [8:0]  d_y;
  logic        d_hs, d_vs, d_de, d_fs, d_vb;
  logic [15:0] d_fc;

  ceespu_video_timing u_dut (
    .I_pix_clk    (clk),
    .I_reset      (rst),
    .O_x          (d_x),
    .O_y          (d_y),
    .O_hsync      (d_hs),
    .O_vsync      (d_vs),
    .O_de         (d_de),
    .O_frame_start(d_fs),
    .O_vblank     (d_vb),
    .O_frame_count(d_fc)
  );

  logic [9:0]  s_x  [NS];
  logic [8:0]  s_y  [NS];
  logic        s_hs [NS];
  logic        s_vs [NS];
  logic        s_de [NS];
  logic        s_fs [NS];
  logic        s_vb [NS];
  logic [15:0] s_fc [NS];

  for (genvar g = 0; g < NS; g++) begin : g_small
    ceespu_video_timing #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .HSYNC_POL(s_pol(g)), .VSYNC_POL(s_pol(g)),
      .PIPE_DELAY(s_pd(g)), .FRAME_COUNT_INIT(s_init(g))
    ) u_dut (
      .I_pix_clk    (clk),
      .I_reset      (rst),
      .O_x          (s_x[g]),
      .O_y          (s_y[g]),
      .O_hsync      (s_hs[g]),
      .O_vsync      (s_vs[g]),
      .O_de         (s_de[g]),
      .O_frame_start(s_fs[g]),
      .O_vblank     (s_vb[g]),
      .O_frame_count(s_fc[g])
    );
  end

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb, pd;
    bit          hpol, vpol;
    logic [15:0] init;
  } cfg_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        hs, vs, de, fs, vb;
    logic [15:0] fc;
  } obs_t;

  function automatic cfg_t cfg_dflt();
    cfg_t c;
    c = '{ha: H_ACTIVE_DEF, hf: H_FP_DEF, hs: H_SYNC_DEF, hb: H_BP_DEF,
          va: V_ACTIVE_DEF, vf: V_FP_DEF, vs: V_SYNC_DEF, vb: V_BP_DEF,
          pd: 2, hpol: 1'b0, vpol: 1'b0, init: 16'h0000};
    return c;
  endfunction

  function automatic cfg_t cfg_small(input int unsigned i);
    cfg_t c;
    c = '{ha: SHA, hf: SHF, hs: SHS, hb: SHB, va: SVA, vf: SVF, vs: SVS, vb: SVB,
          pd: s_pd(i), hpol: s_pol(i), vpol: s_pol(i), init: s_init(i)};
    return c;
  endfunction

  // tt = clock edges since the last edge that saw reset.
  function automatic obs_t model(input int unsigned tt, input cfg_t c);
    int unsigned ht, vt, fr, h, v, td, hd, vd;
    bit hs_raw, vs_raw, de_raw;
    obs_t o;
    ht   = c.ha + c.hf + c.hs + c.hb;
    vt   = c.va + c.vf + c.vs + c.vb;
    fr   = ht * vt;
    h    = tt % ht;
    v    = (tt / ht) % vt;
    o.x  = (h < c.ha) ? 10'(h) : 10'd0;
    o.y  = (v < c.va) ? 9'(v) : 9'd0;
    o.fs = ((tt % fr) == 0);
    o.vb = (v >= c.va);
    o.fc = 16'(32'(c.init) + tt / fr);
    hs_raw = 1'b0;
    vs_raw = 1'b0;
    de_raw = 1'b0;
    if (tt >= c.pd) begin
      td     = tt - c.pd;
      hd     = td % ht;
      vd     = (td / ht) % vt;
      de_raw = (hd < c.ha) && (vd < c.va);
      hs_raw = (hd >= c.ha + c.hf) && (hd < c.ha + c.hf + c.hs);
      vs_raw = (vd >= c.va + c.vf) && (vd < c.va + c.vf + c.vs);
    end
    o.de = de_raw;
    o.hs = hs_raw ? c.hpol : !c.hpol;
    o.vs = vs_raw ? c.vpol : !c.vpol;
    return o;
  endfunction

  // ---------------- checking infrastructure ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned t       = 0;
  bit          armed   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic scoreboard();
    check("sb_default", 64'({d_x, d_y, d_hs, d_vs, d_de, d_fs, d_vb, d_fc}),
          64'(model(t, cfg_dflt())));
    for (int i = 0; i < NS; i++) begin
      check($sformatf("sb_small%0d", i),
            64'({s_x[i], s_y[i], s_hs[i], s_vs[i], s_de[i], s_fs[i], s_vb[i], s_fc[i]}),
            64'(model(t, cfg_small(i))));
    end
  endtask

  // One clock: track raster time at the edge, sample everything on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      t     = 0;
      armed = 1'b1;
    end else begin
      t++;
    end
    @(negedge clk);
    if (armed) scoreboard();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed vectors for the default instance (PIPE_DELAY = 2) ----------------
  typedef struct {
    int unsigned t;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        de, hs, vs, fs, vb;
  } vec_t;

  function automatic vec_t mk(input int unsigned tv, input int unsigned x, input int unsigned y,
                              input bit de, input bit hs, input bit fs);
    vec_t v;
    v = '{t: tv, x: 10'(x), y: 9'(y), de: de, hs: hs, vs: 1'b1, fs: fs, vb: 1'b0};
    return v;
  endfunction

  vec_t        vecs [$];
  int unsigned hs_low, x_err, x_zero;
  int          hs_first, hs_last;
  int unsigned vs_cnt [NS];
  int          vs_first [NS];
  int unsigned vb_cnt [NS], fs_cnt [NS];
  logic [15:0] fc_pre [NS], fc_wrap [NS];
  logic        fs_wrap [NS], de_a [NS], de_b [NS];
  logic [9:0]  x_a [NS], x_b [NS];
  logic [8:0]  y_a [NS];
  int unsigned resid, pre_sync;

  initial begin
    vecs.push_back(mk(0,   0,   0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1,   1,   0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2,   2,   0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(639, 639, 0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(640, 0,   0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(641, 0,   0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(642, 0,   0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(657, 0,   0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(658, 0,   0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(753, 0,   0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(754, 0,   0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(800, 0,   1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(801, 1,   1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(802, 2,   1, 1'b1, 1'b1, 1'b0));

    // Reset held for five cycles, then released on a falling edge.
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    check("reset_frame_count", 64'(d_fc), 64'd0);

    foreach (vecs[k]) begin
      while (t < vecs[k].t) tick();
      check($sformatf("vec%0d_x", k),  64'(d_x),  64'(vecs[k].x));
      check($sformatf("vec%0d_y", k),  64'(d_y),  64'(vecs[k].y));
      check($sformatf("vec%0d_de", k), 64'(d_de), 64'(vecs[k].de));
      check($sformatf("vec%0d_hs", k), 64'(d_hs), 64'(vecs[k].hs));
      check($sformatf("vec%0d_vs", k), 64'(d_vs), 64'(vecs[k].vs));
      check($sformatf("vec%0d_fs", k), 64'(d_fs), 64'(vecs[k].fs));
      check($sformatf("vec%0d_vb", k), 64'(d_vb), 64'(vecs[k].vb));
    end

    // One full line on the default instance: hsync window and x ramp.
    reset_pulse();
    hs_low = 0; hs_first = -1; hs_last = -1; x_err = 0; x_zero = 0;
    for (int k = 0; k < int'(H_TOTAL_DEF) + 4; k++) begin
      if (!d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(t);
        hs_last = int'(t);
      end
      if (t < H_TOTAL_DEF) begin
        if (t < H_ACTIVE_DEF && d_x != 10'(t)) x_err++;
        if (t >= H_ACTIVE_DEF) begin
          if (d_x != 10'd0) x_err++;
          else x_zero++;
        end
      end
      tick();
    end
    check("line_hsync_width", 64'(hs_low), 64'(H_SYNC_DEF));
    check("line_hsync_start", 64'(hs_first), 64'(HS_START_DEF + 2));
    check("line_hsync_end", 64'(hs_last), 64'(HS_END_DEF + 2));
    check("line_x_ramp_errors", 64'(x_err), 64'd0);
    check("line_x_blank_cycles", 64'(x_zero), 64'd160);

    // One full frame on the reduced instances: vsync, vblank, frame pulses, wrap, alignment.
    reset_pulse();
    for (int i = 0; i < NS; i++) begin
      vs_cnt[i] = 0; vs_first[i] = -1; vb_cnt[i] = 0; fs_cnt[i] = 0;
    end
    for (int k = 0; k <= int'(SFR) + 5; k++) begin
      for (int i = 0; i < NS; i++) begin
        if (s_vs[i] == s_pol(i)) begin
          vs_cnt[i]++;
          if (vs_first[i] < 0) vs_first[i] = int'(t);
        end
        if (s_vb[i]) vb_cnt[i]++;
        if (s_fs[i]) fs_cnt[i]++;
        if (t == SFR - 1) fc_pre[i] = s_fc[i];
        if (t == SFR) begin
          fc_wrap[i] = s_fc[i];
          fs_wrap[i] = s_fs[i];
        end
        if (t == T_LAST_PIX) begin
          x_a[i] = s_x[i];
          y_a[i] = s_y[i];
        end
        if (t == T_LAST_PIX + 1) x_b[i] = s_x[i];
        if (t == T_LAST_PIX + s_pd(i)) de_a[i] = s_de[i];
        if (t == T_LAST_PIX + s_pd(i) + 1) de_b[i] = s_de[i];
      end
      tick();
    end
    for (int i = 0; i < NS; i++) begin
      check($sformatf("frame%0d_vsync_cycles", i), 64'(vs_cnt[i]), 64'd64);
      check($sformatf("frame%0d_vsync_start", i), 64'(vs_first[i]), 64'(448 + s_pd(i)));
      check($sformatf("frame%0d_vblank_cycles", i), 64'(vb_cnt[i]), 64'd224);
      check($sformatf("frame%0d_start_pulses", i), 64'(fs_cnt[i]), 64'd2);
      check($sformatf("frame%0d_count_before", i), 64'(fc_pre[i]), 64'(s_init(i)));
      check($sformatf("frame%0d_count_after", i), 64'(fc_wrap[i]),
            (i == 3) ? 64'd0 : 64'd1);
      check($sformatf("frame%0d_start_at_wrap", i), 64'(fs_wrap[i]), 64'd1);
      check($sformatf("align%0d_x_last", i), 64'(x_a[i]), 64'd19);
      check($sformatf("align%0d_y_last", i), 64'(y_a[i]), 64'd11);
      check($sformatf("align%0d_x_after", i), 64'(x_b[i]), 64'd0);
      check($sformatf("align%0d_de_at_last", i), 64'(de_a[i]), 64'd1);
      check($sformatf("align%0d_de_fall", i), 64'(de_b[i]), 64'd0);
    end

    // Single-cycle reset while both syncs are mid-pulse.
    reset_pulse();
    while (t < T_MID_SYNC) tick();
    pre_sync = 0;
    for (int i = 0; i < NS; i++) begin
      if (s_hs[i] == s_pol(i) && s_vs[i] == s_pol(i)) pre_sync++;
    end
    check("midsync_both_asserted", 64'(pre_sync), 64'(NS));
    reset_pulse();
    for (int i = 0; i < NS; i++) begin
      check($sformatf("midsync%0d_xy", i), 64'({s_x[i], s_y[i]}), 64'd0);
      check($sformatf("midsync%0d_hsync_idle", i), 64'(s_hs[i]), 64'(!s_pol(i)));
      check($sformatf("midsync%0d_vsync_idle", i), 64'(s_vs[i]), 64'(!s_pol(i)));
      check($sformatf("midsync%0d_de_low", i), 64'(s_de[i]), 64'd0);
      check($sformatf("midsync%0d_frame_start", i), 64'(s_fs[i]), 64'd1);
    end
    resid = 0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NS; i++) begin
        if (s_hs[i] == s_pol(i) || s_vs[i] == s_pol(i)) resid++;
        if (t < s_pd(i) && s_de[i]) resid++;
        if (t == s_pd(i) && !s_de[i]) resid++;
      end
      tick();
    end
    check("midsync_residual_events", 64'(resid), 64'd0);

    // Free run with random reset pulses; the per-cycle model comparison does the checking.
    for (int k = 0; k < 15000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
